// File: rtl/temp_sampler_if.sv
// DRP request/response plus published temperature bundle between the sampler and its neighbours.
// The sampler drives the DRP as master; the XADC/consumer side uses the slave view.
interface temp_sampler_if;
   logic        enable;
   logic        drdy;
   logic [15:0] doData;
   logic        den;
   logic [6:0]  daddr;
   logic [11:0] digitalTemp;
   logic        ready;
   logic        fault;

   modport master (
      input  enable, drdy, doData,
      output den, daddr, digitalTemp, ready, fault
   );

   modport slave (
      output enable, drdy, doData,
      input  den, daddr, digitalTemp, ready, fault
   );
endinterface

// File: rtl/temp_sampler.sv
// Periodic XADC temperature poller averaging 2^AVG_LOG2 reads; publishes one cycle after the final drdy.
// No backpressure: ticks landing outside IDLE are dropped, a missing drdy trips a sticky fault after TIMEOUT cycles.
module temp_sampler #(
   parameter int unsigned SAMPLE_DIV = 100000,
   parameter int unsigned AVG_LOG2   = 2,
   parameter logic [6:0]  DRP_ADDR   = 7'h00,
   parameter int unsigned TIMEOUT    = 255
) (
   input  logic            core_clk,
   input  logic            arst_n,
   temp_sampler_if.master  bus
);

   localparam int unsigned TICK_W = $clog2(SAMPLE_DIV);
   localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
   localparam int unsigned NSAMP  = 1 << AVG_LOG2;
   localparam int unsigned ACC_W  = 12 + AVG_LOG2;
   localparam int unsigned CNT_W  = AVG_LOG2 + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
   logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [CNT_W-1:0]    smp_cnt_q, smp_cnt_d;
   logic [11:0]         temp_q, temp_d;
   logic                ready_q, ready_d;
   logic                fault_q, fault_d;
   logic                den_q, den_d;

   logic                tick;
   logic [11:0]         sample;
   logic [ACC_W-1:0]    sum;
   logic [ACC_W-1:0]    sum_sh;
   logic [3:0]          unused_dodata;

   assign sample        = bus.doData[15:4];
   assign unused_dodata = bus.doData[3:0];
   assign sum           = acc_q + ACC_W'(sample);
   assign sum_sh        = sum >> AVG_LOG2;

   always_comb begin
      tick_cnt_d = tick_cnt_q;
      tick       = 1'b0;
      if (!bus.enable) begin
         tick_cnt_d = '0;
      end else if (tick_cnt_q == TICK_W'(SAMPLE_DIV - 1)) begin
         tick       = 1'b1;
         tick_cnt_d = '0;
      end else begin
         tick_cnt_d = tick_cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      to_cnt_d  = to_cnt_q;
      acc_d     = acc_q;
      smp_cnt_d = smp_cnt_q;
      temp_d    = temp_q;
      ready_d   = ready_q;
      fault_d   = fault_q;
      den_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (!bus.enable) begin
               acc_d     = '0;
               smp_cnt_d = '0;
            end else if (tick) begin
               state_d = S_REQ;
               den_d   = 1'b1;
            end
         end
         S_REQ: begin
            // The den cycle itself counts, so fault lands exactly TIMEOUT cycles after den.
            to_cnt_d = TO_W'(1);
            state_d  = S_WAIT;
         end
         S_WAIT: begin
            if (bus.drdy) begin
               state_d = S_IDLE;
               if (smp_cnt_q == CNT_W'(NSAMP - 1)) begin
                  temp_d    = sum_sh[11:0];
                  ready_d   = 1'b1;
                  fault_d   = 1'b0;
                  acc_d     = '0;
                  smp_cnt_d = '0;
               end else begin
                  acc_d     = sum;
                  smp_cnt_d = smp_cnt_q + 1'b1;
               end
            end else if (to_cnt_q == TO_W'(TIMEOUT - 1)) begin
               state_d   = S_IDLE;
               fault_d   = 1'b1;
               ready_d   = 1'b0;
               acc_d     = '0;
               smp_cnt_d = '0;
            end else begin
               to_cnt_d = to_cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge core_clk or negedge arst_n) begin
      if (!arst_n) begin
         state_q    <= S_IDLE;
         tick_cnt_q <= '0;
         to_cnt_q   <= '0;
         acc_q      <= '0;
         smp_cnt_q  <= '0;
         temp_q     <= '0;
         ready_q    <= 1'b0;
         fault_q    <= 1'b0;
         den_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         to_cnt_q   <= to_cnt_d;
         acc_q      <= acc_d;
         smp_cnt_q  <= smp_cnt_d;
         temp_q     <= temp_d;
         ready_q    <= ready_d;
         fault_q    <= fault_d;
         den_q      <= den_d;
      end
   end

   assign bus.den         = den_q;
   assign bus.daddr       = DRP_ADDR;
   assign bus.digitalTemp = temp_q;
   assign bus.ready       = ready_q;
   assign bus.fault       = fault_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Directed bench for temp_sampler: reset, averaging, timeout, stray/simultaneous drdy, enable drop.
module tb_temp_sampler;

   logic core_clk = 1'b0;
   logic arst_n   = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;

   temp_sampler_if bus_if();

   temp_sampler #(
      .SAMPLE_DIV (20),
      .AVG_LOG2   (2),
      .DRP_ADDR   (7'h00),
      .TIMEOUT    (8)
   ) dut (
      .core_clk (core_clk),
      .arst_n   (arst_n),
      .bus      (bus_if)
   );

   always #5 core_clk = ~core_clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge core_clk);
      #1;
   endtask

   // Leaves the bench in the cycle where den is high.
   task automatic wait_den();
      int n = 0;
      while (bus_if.den !== 1'b1 && n < 60) begin
         step();
         n++;
      end
      check("den_seen", bus_if.den, 1);
   endtask

   // drdy is high dly cycles after the den cycle; returns the cycle after drdy.
   task automatic pulse(input logic [11:0] code, input int dly);
      repeat (dly) step();
      bus_if.drdy   = 1'b1;
      bus_if.doData = {code, 4'h0};
      step();
      bus_if.drdy   = 1'b0;
      bus_if.doData = '0;
   endtask

   task automatic do_read(input logic [11:0] code, input int dly);
      wait_den();
      pulse(code, dly);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int lat;
      int seen;
      logic [11:0] mix [4];

      bus_if.enable = 1'b0;
      bus_if.drdy   = 1'b0;
      bus_if.doData = '0;
      step();
      step();
      check("rst_den",   bus_if.den, 0);
      check("rst_ready", bus_if.ready, 0);
      check("rst_fault", bus_if.fault, 0);
      check("rst_temp",  bus_if.digitalTemp, 0);
      check("daddr",     bus_if.daddr, 7'h00);

      // First den follows the first full tick period after release.
      arst_n        = 1'b1;
      bus_if.enable = 1'b1;
      lat = 0;
      while (bus_if.den !== 1'b1 && lat < 60) begin
         step();
         lat++;
      end
      check("first_den_lat", lat, 20);

      // Constant input, 4 x 1700.
      for (int i = 0; i < 3; i++) begin
         do_read(12'd1700, 3);
         check("const_ready_hold", bus_if.ready, 0);
         check("const_temp_hold", bus_if.digitalTemp, 0);
      end
      do_read(12'd1700, 3);
      check("const_ready", bus_if.ready, 1);
      check("const_temp", bus_if.digitalTemp, 1700);
      step();
      check("den_one_cycle_idle", bus_if.den, 0);

      // Mixed average with truncation: 7345/4 = 1836.
      mix[0] = 12'd1020; mix[1] = 12'd1020; mix[2] = 12'd2652; mix[3] = 12'd2653;
      for (int i = 0; i < 3; i++) begin
         do_read(mix[i], 3);
         check("mix_temp_hold", bus_if.digitalTemp, 1700);
      end
      do_read(mix[3], 3);
      check("mix_temp", bus_if.digitalTemp, 1836);
      for (int i = 0; i < 4; i++) do_read(12'd1020, 3);
      check("mix2_temp", bus_if.digitalTemp, 1020);

      // Timeout: no drdy, fault exactly 8 cycles after den.
      wait_den();
      step();
      check("den_pulse_width", bus_if.den, 0);
      repeat (6) step();
      check("to_fault_early", bus_if.fault, 0);
      step();
      check("to_fault", bus_if.fault, 1);
      check("to_ready", bus_if.ready, 0);
      check("to_temp_kept", bus_if.digitalTemp, 1020);
      do_read(12'd2000, 3);
      check("to_fault_sticky", bus_if.fault, 1);
      for (int i = 0; i < 3; i++) do_read(12'd2000, 3);
      check("recover_fault", bus_if.fault, 0);
      check("recover_ready", bus_if.ready, 1);
      check("recover_temp", bus_if.digitalTemp, 2000);

      // Stray drdy in IDLE must not count as a sample.
      do_read(12'd100, 3);
      bus_if.drdy   = 1'b1;
      bus_if.doData = {12'd4095, 4'h0};
      step();
      bus_if.drdy   = 1'b0;
      bus_if.doData = '0;
      do_read(12'd100, 3);
      do_read(12'd100, 3);
      check("stray_no_early_pub", bus_if.digitalTemp, 2000);
      do_read(12'd100, 3);
      check("stray_temp", bus_if.digitalTemp, 100);

      // drdy on the timeout cycle wins; also the earliest drdy slot. 1206/4 = 301.
      do_read(12'd300, 7);
      check("simul_no_fault", bus_if.fault, 0);
      do_read(12'd301, 1);
      do_read(12'd302, 7);
      do_read(12'd303, 7);
      check("simul_temp", bus_if.digitalTemp, 301);
      check("simul_fault", bus_if.fault, 0);

      // Enable drop during WAIT after two samples.
      do_read(12'd500, 3);
      do_read(12'd500, 3);
      wait_den();
      step();
      bus_if.enable = 1'b0;
      pulse(12'd500, 2);
      check("drop_ready", bus_if.ready, 1);
      check("drop_temp", bus_if.digitalTemp, 301);
      seen = 0;
      repeat (40) begin
         step();
         if (bus_if.den === 1'b1) seen++;
      end
      check("drop_parked", seen, 0);
      bus_if.enable = 1'b1;
      for (int i = 0; i < 3; i++) do_read(12'd800, 3);
      check("reen_no_early_pub", bus_if.digitalTemp, 301);
      do_read(12'd800, 3);
      check("reen_temp", bus_if.digitalTemp, 800);

      // Asynchronous reset in the middle of WAIT.
      wait_den();
      repeat (2) step();
      arst_n = 1'b0;
      #1;
      check("midrst_den",   bus_if.den, 0);
      check("midrst_ready", bus_if.ready, 0);
      check("midrst_fault", bus_if.fault, 0);
      check("midrst_temp",  bus_if.digitalTemp, 0);
      step();
      arst_n = 1'b1;
      step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
